// File: rtl/dac_sample_select_pkg.sv
// -----------------------------------------------------------------------------
// dac_sample_select_pkg
//
// Shared types, widths and defaults for the DAC sample-selection block and its
// threshold comparator. The threshold comparator is also intended for reuse by
// later TTL/threshold output logic, so the data widths live here rather than in
// the top module.
// -----------------------------------------------------------------------------
package dac_sample_select_pkg;

  // Field widths of the amplifier sample stream and sequencer state.
  localparam int STATE_W   = 32;
  localparam int STREAM_W  = 5;
  localparam int CHANNEL_W = 6;
  localparam int SAMPLE_W  = 16;
  localparam int STALE_W   = 8;

  // Main sequencer state at which a frame boundary occurs.
  localparam logic [STATE_W-1:0] MS_WAIT = 32'd99;

  // Offset-binary zero: the DAC output value after reset.
  localparam logic [SAMPLE_W-1:0] DAC_MIDSCALE = 16'h8000;

  // Default saturation value of the stale-frame counter.
  localparam logic [STALE_W-1:0] STALE_MAX_DEF = 8'd255;

  // Configuration snapshot taken at each frame boundary. Everything the
  // datapath uses from the host side is read from this snapshot only, so
  // host writes between boundaries never disturb a frame in progress.
  typedef struct packed {
    logic [STREAM_W-1:0]  stream;
    logic [CHANNEL_W-1:0] channel;
    logic                 manual_en;
    logic [SAMPLE_W-1:0]  manual;
    logic [SAMPLE_W-1:0]  thresh;
    logic                 pol;
    logic                 thresh_en;
  } dac_cfg_t;

  // Source chosen for DAC_input at a transfer.
  typedef enum logic [1:0] {
    SRC_HOLD   = 2'd0,
    SRC_MANUAL = 2'd1,
    SRC_SHADOW = 2'd2
  } dac_src_e;

  // Saturating increment of the stale-frame counter.
  function automatic logic [STALE_W-1:0] stale_inc(
    input logic [STALE_W-1:0] value,
    input logic [STALE_W-1:0] max_value
  );
    if (value >= max_value) begin
      return max_value;
    end
    return value + STALE_W'(1);
  endfunction

endpackage : dac_sample_select_pkg

// File: rtl/dac_threshold_compare.sv
// -----------------------------------------------------------------------------
// dac_threshold_compare
//
// Registered threshold-crossing flag for an offset-binary value. Offset binary
// preserves signed ordering, so a plain unsigned compare is correct.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (flag clears to 0)
//   dac_i    in   value under test (already registered upstream)
//   thresh_i in   threshold
//   pol_i    in   1: flag when dac_i >= thresh_i; 0: flag when dac_i <= thresh_i
//   en_i     in   compare enable; flag is forced low when 0
//   flag_o   out  registered result, one cycle behind its inputs
// -----------------------------------------------------------------------------
module dac_threshold_compare
  import dac_sample_select_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] dac_i,
  input  logic [W-1:0] thresh_i,
  input  logic         pol_i,
  input  logic         en_i,
  output logic         flag_o
);

  logic flag_q;
  logic flag_d;

  always_comb begin
    flag_d = 1'b0;
    if (en_i) begin
      if (pol_i) begin
        flag_d = (dac_i >= thresh_i);
      end else begin
        flag_d = (dac_i <= thresh_i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule : dac_threshold_compare

// File: rtl/dac_sample_select.sv
// -----------------------------------------------------------------------------
// dac_sample_select
//
// Feeder for the AD5662 DAC serializer. Watches the per-sample amplifier data
// stream, captures the most recent sample of one selected (stream, channel)
// pair into a shadow register, and transfers either that sample or a manual
// value to DAC_input only at the frame boundary (main_state == ms_wait), so
// the value is stable while the serializer shifts it out.
//
// Ports:
//   dataclk          in   data clock, all logic on rising edge
//   reset_n          in   asynchronous active-low reset
//   main_state       in   main sequencer state; ms_wait marks frame boundary
//   sample_valid     in   one-cycle strobe qualifying sample_* fields
//   sample_stream    in   stream index of current sample
//   sample_channel   in   channel index of current sample
//   sample_data      in   amplifier sample, offset binary
//   DAC_stream_sel   in   requested stream         (latched at boundary)
//   DAC_channel_sel  in   requested channel        (latched at boundary)
//   DAC_manual_en    in   select manual value      (latched at boundary)
//   DAC_manual       in   manual value             (latched at boundary)
//   DAC_thresh       in   threshold                (latched at boundary)
//   DAC_thresh_pol   in   threshold polarity       (latched at boundary)
//   DAC_thresh_en    in   threshold enable         (latched at boundary)
//   DAC_input        out  value to DAC output stage
//   DAC_stale        out  1 = last transfer had no fresh sample
//   DAC_thresh_out   out  registered threshold flag, lags DAC_input by 1 cycle
//   stale_count      out  consecutive stale transfers, saturating
// -----------------------------------------------------------------------------
module dac_sample_select
  import dac_sample_select_pkg::*;
#(
  parameter logic [STATE_W-1:0] ms_wait   = MS_WAIT,
  parameter logic [STALE_W-1:0] STALE_MAX = STALE_MAX_DEF
) (
  input  logic                 dataclk,
  input  logic                 reset_n,
  input  logic [STATE_W-1:0]   main_state,
  input  logic                 sample_valid,
  input  logic [STREAM_W-1:0]  sample_stream,
  input  logic [CHANNEL_W-1:0] sample_channel,
  input  logic [SAMPLE_W-1:0]  sample_data,
  input  logic [STREAM_W-1:0]  DAC_stream_sel,
  input  logic [CHANNEL_W-1:0] DAC_channel_sel,
  input  logic                 DAC_manual_en,
  input  logic [SAMPLE_W-1:0]  DAC_manual,
  input  logic [SAMPLE_W-1:0]  DAC_thresh,
  input  logic                 DAC_thresh_pol,
  input  logic                 DAC_thresh_en,
  output logic [SAMPLE_W-1:0]  DAC_input,
  output logic                 DAC_stale,
  output logic                 DAC_thresh_out,
  output logic [STALE_W-1:0]   stale_count
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  dac_cfg_t              cfg_q,    cfg_d;
  logic [SAMPLE_W-1:0]   shadow_q, shadow_d;
  logic                  hit_q,    hit_d;
  logic [SAMPLE_W-1:0]   dac_q,    dac_d;
  logic                  stale_q,  stale_d;
  logic [STALE_W-1:0]    count_q,  count_d;

  logic                  boundary;
  logic                  match;
  dac_src_e              src;

  assign boundary = (main_state == ms_wait);

  // Matching uses the configuration held before this edge, so a selection
  // change only takes effect for samples after the next boundary.
  assign match = sample_valid
              && (sample_stream  == cfg_q.stream)
              && (sample_channel == cfg_q.channel);

  // ---------------------------------------------------------------------------
  // Configuration snapshot
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_d = cfg_q;
    if (boundary) begin
      cfg_d.stream    = DAC_stream_sel;
      cfg_d.channel   = DAC_channel_sel;
      cfg_d.manual_en = DAC_manual_en;
      cfg_d.manual    = DAC_manual;
      cfg_d.thresh    = DAC_thresh;
      cfg_d.pol       = DAC_thresh_pol;
      cfg_d.thresh_en = DAC_thresh_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture into the shadow register
  // ---------------------------------------------------------------------------
  // A match coinciding with a boundary belongs to the next frame: it loads the
  // shadow and re-arms hit, while the transfer on that same edge still uses the
  // pre-edge shadow/hit values.
  always_comb begin
    shadow_d = shadow_q;
    hit_d    = hit_q;
    if (match) begin
      shadow_d = sample_data;
      hit_d    = 1'b1;
    end else if (boundary) begin
      hit_d    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer to DAC_input at the frame boundary
  // ---------------------------------------------------------------------------
  always_comb begin
    src = SRC_HOLD;
    if (cfg_q.manual_en) begin
      src = SRC_MANUAL;
    end else if (hit_q) begin
      src = SRC_SHADOW;
    end
  end

  always_comb begin
    dac_d   = dac_q;
    stale_d = stale_q;
    count_d = count_q;
    if (boundary) begin
      unique case (src)
        SRC_MANUAL: begin
          dac_d   = cfg_q.manual;
          stale_d = 1'b0;
        end
        SRC_SHADOW: begin
          dac_d   = shadow_q;
          stale_d = 1'b0;
        end
        default: begin
          stale_d = 1'b1;
        end
      endcase
      count_d = stale_d ? stale_inc(count_q, STALE_MAX) : '0;
    end
  end

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q    <= '0;
      shadow_q <= DAC_MIDSCALE;
      hit_q    <= 1'b0;
      dac_q    <= DAC_MIDSCALE;
      stale_q  <= 1'b1;
      count_q  <= '0;
    end else begin
      cfg_q    <= cfg_d;
      shadow_q <= shadow_d;
      hit_q    <= hit_d;
      dac_q    <= dac_d;
      stale_q  <= stale_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold flag: compares the registered DAC_input, hence the 1-cycle lag
  // ---------------------------------------------------------------------------
  dac_threshold_compare #(
    .W (SAMPLE_W)
  ) u_thresh (
    .clk      (dataclk),
    .rst_n    (reset_n),
    .dac_i    (dac_q),
    .thresh_i (cfg_q.thresh),
    .pol_i    (cfg_q.pol),
    .en_i     (cfg_q.thresh_en),
    .flag_o   (DAC_thresh_out)
  );

  assign DAC_input   = dac_q;
  assign DAC_stale   = stale_q;
  assign stale_count = count_q;

endmodule : dac_sample_select

// File: tb/tb_dac_sample_select.sv
module tb_dac_sample_select;

  logic        dataclk;
  logic        reset_n;
  logic [31:0] main_state;
  logic        sample_valid;
  logic [4:0]  sample_stream;
  logic [5:0]  sample_channel;
  logic [15:0] sample_data;
  logic [4:0]  DAC_stream_sel;
  logic [5:0]  DAC_channel_sel;
  logic        DAC_manual_en;
  logic [15:0] DAC_manual;
  logic [15:0] DAC_thresh;
  logic        DAC_thresh_pol;
  logic        DAC_thresh_en;
  logic [15:0] DAC_input;
  logic        DAC_stale;
  logic        DAC_thresh_out;
  logic [7:0]  stale_count;

  int n_checks = 0;
  int n_fail   = 0;

  dac_sample_select dut (
    .dataclk         (dataclk),
    .reset_n         (reset_n),
    .main_state      (main_state),
    .sample_valid    (sample_valid),
    .sample_stream   (sample_stream),
    .sample_channel  (sample_channel),
    .sample_data     (sample_data),
    .DAC_stream_sel  (DAC_stream_sel),
    .DAC_channel_sel (DAC_channel_sel),
    .DAC_manual_en   (DAC_manual_en),
    .DAC_manual      (DAC_manual),
    .DAC_thresh      (DAC_thresh),
    .DAC_thresh_pol  (DAC_thresh_pol),
    .DAC_thresh_en   (DAC_thresh_en),
    .DAC_input       (DAC_input),
    .DAC_stale       (DAC_stale),
    .DAC_thresh_out  (DAC_thresh_out),
    .stale_count     (stale_count)
  );

  initial dataclk = 1'b0;
  always #5 dataclk = ~dataclk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge dataclk);
    #1;
  endtask

  task automatic boundary();
    main_state = 32'd99;
    tick();
    main_state = 32'd0;
  endtask

  task automatic send(input logic [4:0] s, input logic [5:0] c, input logic [15:0] d);
    sample_valid   = 1'b1;
    sample_stream  = s;
    sample_channel = c;
    sample_data    = d;
    tick();
    sample_valid   = 1'b0;
  endtask

  task automatic test_reset();
    $display("test_reset");
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++; if (DAC_input !== 16'h8000) begin n_fail++; $display("FAIL reset_dac: got %h expected 8000", DAC_input); end
    n_checks++; if (DAC_stale !== 1'b1) begin n_fail++; $display("FAIL reset_stale: got %b expected 1", DAC_stale); end
    n_checks++; if (DAC_thresh_out !== 1'b0) begin n_fail++; $display("FAIL reset_thresh: got %b expected 0", DAC_thresh_out); end
    n_checks++; if (stale_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", stale_count); end
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      boundary();
      tick();
    end
    n_checks++; if (DAC_input !== 16'h8000) begin n_fail++; $display("FAIL idle_dac: got %h expected 8000", DAC_input); end
    n_checks++; if (DAC_stale !== 1'b1) begin n_fail++; $display("FAIL idle_stale: got %b expected 1", DAC_stale); end
    n_checks++; if (stale_count !== 8'd3) begin n_fail++; $display("FAIL idle_count: got %0d expected 3", stale_count); end
    n_checks++; if (DAC_thresh_out !== 1'b0) begin n_fail++; $display("FAIL idle_thresh: got %b expected 0", DAC_thresh_out); end
  endtask

  task automatic test_capture();
    $display("test_capture");
    DAC_stream_sel  = 5'd2;
    DAC_channel_sel = 6'd5;
    boundary();
    n_checks++; if (stale_count !== 8'd4) begin n_fail++; $display("FAIL latch_count: got %0d expected 4", stale_count); end
    tick();
    send(5'd2, 6'd5, 16'h1234);
    send(5'd2, 6'd5, 16'hABCD);
    send(5'd3, 6'd5, 16'hFFFF);
    tick();
    boundary();
    n_checks++; if (DAC_input !== 16'hABCD) begin n_fail++; $display("FAIL capture_dac: got %h expected abcd", DAC_input); end
    n_checks++; if (DAC_stale !== 1'b0) begin n_fail++; $display("FAIL capture_stale: got %b expected 0", DAC_stale); end
    n_checks++; if (stale_count !== 8'd0) begin n_fail++; $display("FAIL capture_count: got %0d expected 0", stale_count); end
  endtask

  task automatic test_coincident();
    $display("test_coincident");
    tick();
    send(5'd2, 6'd5, 16'h1111);
    tick();
    // Matching sample on the boundary cycle itself.
    sample_valid   = 1'b1;
    sample_stream  = 5'd2;
    sample_channel = 6'd5;
    sample_data    = 16'h4444;
    main_state     = 32'd99;
    tick();
    main_state     = 32'd0;
    sample_valid   = 1'b0;
    n_checks++; if (DAC_input !== 16'h1111) begin n_fail++; $display("FAIL coinc_dac: got %h expected 1111", DAC_input); end
    tick();
    tick();
    boundary();
    n_checks++; if (DAC_input !== 16'h4444) begin n_fail++; $display("FAIL coinc_next_dac: got %h expected 4444", DAC_input); end
    n_checks++; if (DAC_stale !== 1'b0) begin n_fail++; $display("FAIL coinc_next_stale: got %b expected 0", DAC_stale); end
  endtask

  task automatic test_sel_change();
    $display("test_sel_change");
    tick();
    DAC_channel_sel = 6'd7;
    tick();
    send(5'd2, 6'd7, 16'h7777);
    tick();
    boundary();
    n_checks++; if (DAC_input !== 16'h4444) begin n_fail++; $display("FAIL selchg_dac: got %h expected 4444", DAC_input); end
    n_checks++; if (DAC_stale !== 1'b1) begin n_fail++; $display("FAIL selchg_stale: got %b expected 1", DAC_stale); end
    n_checks++; if (stale_count !== 8'd1) begin n_fail++; $display("FAIL selchg_count: got %0d expected 1", stale_count); end
    tick();
    send(5'd2, 6'd7, 16'h7777);
    boundary();
    n_checks++; if (DAC_input !== 16'h7777) begin n_fail++; $display("FAIL selnew_dac: got %h expected 7777", DAC_input); end
    n_checks++; if (DAC_stale !== 1'b0) begin n_fail++; $display("FAIL selnew_stale: got %b expected 0", DAC_stale); end
  endtask

  task automatic test_manual();
    $display("test_manual");
    DAC_manual_en = 1'b1;
    DAC_manual    = 16'h0000;
    send(5'd2, 6'd7, 16'h2222);
    boundary();   // manual latched here; captured sample still used
    n_checks++; if (DAC_input !== 16'h2222) begin n_fail++; $display("FAIL man_latch_dac: got %h expected 2222", DAC_input); end
    send(5'd2, 6'd7, 16'h3333);
    boundary();
    n_checks++; if (DAC_input !== 16'h0000) begin n_fail++; $display("FAIL man_dac: got %h expected 0000", DAC_input); end
    n_checks++; if (DAC_stale !== 1'b0) begin n_fail++; $display("FAIL man_stale: got %b expected 0", DAC_stale); end
    DAC_manual_en = 1'b0;
    send(5'd2, 6'd7, 16'h5555);
    boundary();
    n_checks++; if (DAC_input !== 16'h0000) begin n_fail++; $display("FAIL man_off1_dac: got %h expected 0000", DAC_input); end
    send(5'd2, 6'd7, 16'h6666);
    boundary();
    n_checks++; if (DAC_input !== 16'h6666) begin n_fail++; $display("FAIL man_off2_dac: got %h expected 6666", DAC_input); end
  endtask

  task automatic test_threshold();
    $display("test_threshold");
    DAC_thresh     = 16'h9000;
    DAC_thresh_pol = 1'b1;
    DAC_thresh_en  = 1'b1;
    DAC_manual_en  = 1'b1;
    DAC_manual     = 16'h8FFF;
    tick();
    boundary();   // A: config latched
    DAC_manual = 16'h9000;
    tick();
    boundary();   // B: DAC_input -> 8FFF
    n_checks++; if (DAC_input !== 16'h8FFF) begin n_fail++; $display("FAIL th_dac_8fff: got %h expected 8fff", DAC_input); end
    tick();
    n_checks++; if (DAC_thresh_out !== 1'b0) begin n_fail++; $display("FAIL th_8fff_ge: got %b expected 0", DAC_thresh_out); end
    boundary();   // C: DAC_input -> 9000
    n_checks++; if (DAC_input !== 16'h9000) begin n_fail++; $display("FAIL th_dac_9000: got %h expected 9000", DAC_input); end
    n_checks++; if (DAC_thresh_out !== 1'b0) begin n_fail++; $display("FAIL th_lag: got %b expected 0", DAC_thresh_out); end
    tick();
    n_checks++; if (DAC_thresh_out !== 1'b1) begin n_fail++; $display("FAIL th_9000_ge: got %b expected 1", DAC_thresh_out); end
    DAC_thresh_pol = 1'b0;
    boundary();   // D: pol 0 latched
    tick();
    n_checks++; if (DAC_thresh_out !== 1'b1) begin n_fail++; $display("FAIL th_9000_le_eq: got %b expected 1", DAC_thresh_out); end
    DAC_thresh = 16'h8FFF;
    boundary();   // E
    tick();
    n_checks++; if (DAC_thresh_out !== 1'b0) begin n_fail++; $display("FAIL th_9000_le_8fff: got %b expected 0", DAC_thresh_out); end
    DAC_thresh_en = 1'b0;
    DAC_thresh    = 16'h9000;
    boundary();   // F: enable off
    tick();
    n_checks++; if (DAC_thresh_out !== 1'b0) begin n_fail++; $display("FAIL th_disabled: got %b expected 0", DAC_thresh_out); end
    DAC_thresh_en = 1'b1;
    boundary();   // G: enabled again, 9000 <= 9000
    tick();
    n_checks++; if (DAC_thresh_out !== 1'b1) begin n_fail++; $display("FAIL th_reenabled: got %b expected 1", DAC_thresh_out); end
  endtask

  task automatic test_async_reset();
    $display("test_async_reset");
    DAC_manual_en = 1'b0;
    send(5'd2, 6'd7, 16'h2468);
    #2;
    reset_n = 1'b0;   // mid-cycle, no clock edge involved
    #1;
    n_checks++; if (DAC_input !== 16'h8000) begin n_fail++; $display("FAIL areset_dac: got %h expected 8000", DAC_input); end
    n_checks++; if (DAC_stale !== 1'b1) begin n_fail++; $display("FAIL areset_stale: got %b expected 1", DAC_stale); end
    n_checks++; if (DAC_thresh_out !== 1'b0) begin n_fail++; $display("FAIL areset_thresh: got %b expected 0", DAC_thresh_out); end
    n_checks++; if (stale_count !== 8'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", stale_count); end
    #2;
    reset_n = 1'b1;
    tick();
    boundary();
    n_checks++; if (DAC_input !== 16'h8000) begin n_fail++; $display("FAIL post_reset_dac: got %h expected 8000", DAC_input); end
    n_checks++; if (DAC_stale !== 1'b1) begin n_fail++; $display("FAIL post_reset_stale: got %b expected 1", DAC_stale); end
    n_checks++; if (stale_count !== 8'd1) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 1", stale_count); end
    send(5'd2, 6'd7, 16'h1357);
    boundary();
    n_checks++; if (DAC_input !== 16'h1357) begin n_fail++; $display("FAIL post_reset_capture: got %h expected 1357", DAC_input); end
  endtask

  task automatic test_stale_saturation();
    $display("test_stale_saturation");
    for (int i = 0; i < 254; i++) begin
      boundary();
      tick();
    end
    n_checks++; if (stale_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", stale_count); end
    for (int i = 0; i < 6; i++) begin
      boundary();
      tick();
    end
    n_checks++; if (stale_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d expected 255", stale_count); end
    n_checks++; if (DAC_input !== 16'h1357) begin n_fail++; $display("FAIL sat_hold_dac: got %h expected 1357", DAC_input); end
    send(5'd2, 6'd7, 16'h0F0F);
    boundary();
    n_checks++; if (stale_count !== 8'd0) begin n_fail++; $display("FAIL sat_clear: got %0d expected 0", stale_count); end
  endtask

  initial begin
    reset_n         = 1'b0;
    main_state      = 32'd0;
    sample_valid    = 1'b0;
    sample_stream   = 5'd0;
    sample_channel  = 6'd0;
    sample_data     = 16'h0000;
    DAC_stream_sel  = 5'd0;
    DAC_channel_sel = 6'd0;
    DAC_manual_en   = 1'b0;
    DAC_manual      = 16'h0000;
    DAC_thresh      = 16'h0000;
    DAC_thresh_pol  = 1'b0;
    DAC_thresh_en   = 1'b0;

    test_reset();
    test_capture();
    test_coincident();
    test_sel_change();
    test_manual();
    test_threshold();
    test_async_reset();
    test_stale_saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dac_sample_select
